// File: rtl/iter_div_pkg.sv
// Shared constants and types for the iterative divider.
// FSM encodings live here so other blocks can decode them.
package iter_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/iter_div_step.sv
// One restoring radix-2 divide iteration.
// Shift in the next dividend bit, trial subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // trial subtraction of divisor from the shifted partial remainder
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    borrow  = diff[WIDTH+1];
    rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    q_bit   = ~borrow;
  end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed divides run on magnitudes and fix signs on the last step.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_flush,
  input  logic             div_valid,
  output logic             div_i_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_o_valid,
  input  logic             div_o_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);

  div_state_t state_q;
  div_state_t state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic             accept;
  logic             div_zero;
  logic             ovf;
  logic             last;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] q_raw;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // request decode, operand magnitudes and final sign fix-up
  always_comb begin
    accept   = div_valid && div_i_ready && !div_flush;
    div_zero = (divisor == '0);
    ovf      = div_signed && (dividend == MIN_NEG)
             && (divisor == '1);
    a_neg    = div_signed & dividend[WIDTH-1];
    b_neg    = div_signed & divisor[WIDTH-1];
    abs_a    = a_neg ? -dividend : dividend;
    abs_b    = b_neg ? -divisor : divisor;
    last     = (cnt_q == LAST);
    q_raw    = (dvd_q << 1) | WIDTH'(step_qbit);
    q_fin    = neg_q_q ? -q_raw : q_raw;
    r_fin    = neg_r_q ? -step_rem : step_rem;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .divisor(dvs_q),
    .bit_in (dvd_q[WIDTH-1]),
    .rem_out(step_rem),
    .q_bit  (step_qbit)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (div_flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (accept)
                state_d = (div_zero || ovf) ? DONE : CALC;
        CALC: if (last) state_d = DONE;
        DONE: if (div_o_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    div_i_ready = (state_q == IDLE);
    div_o_valid = (state_q == DONE);
  end

  // operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= abs_a;
      dvs_q   <= abs_b;
      neg_q_q <= a_neg ^ b_neg;
      neg_r_q <= a_neg;
      if (div_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (ovf) begin
        quotient  <= dividend;
        remainder <= '0;
      end
    end else if (div_flush) begin
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= step_rem;
      dvd_q <= q_raw;
      if (last) begin
        cnt_q     <= '0;
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Directed and random bench for iter_div.
// Expected results queue up at issue and are checked at output.
module tb_iter_div;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         div_flush;
  logic         div_valid;
  logic         div_i_ready;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_o_valid;
  logic         div_o_ready;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  iter_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_flush  (div_flush),
    .div_valid  (div_valid),
    .div_i_ready(div_i_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_o_valid(div_o_valid),
    .div_o_ready(div_o_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(bit sg, logic [W-1:0] a,
                                 logic [W-1:0] b);
    exp_t e;
    logic [W-1:0] mn;
    mn = '0;
    mn[W-1] = 1'b1;
    if (b == '0) begin
      e.q = '1; e.r = a; e.lat = 1;
    end else if (sg && a == mn && b == '1) begin
      e.q = a; e.r = '0; e.lat = 1;
    end else if (sg) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
      e.lat = W + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = W + 1;
    end
    return e;
  endfunction

  function automatic exp_t mk(logic [W-1:0] q, logic [W-1:0] r,
                              int lat);
    exp_t e;
    e.q = q; e.r = r; e.lat = lat;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present a request and take the acceptance edge (cycle 0)
  task automatic issue(bit sg, logic [W-1:0] a, logic [W-1:0] b);
    int n;
    n = 0;
    div_signed = sg;
    dividend = a;
    divisor = b;
    div_valid = 1'b1;
    while (!div_i_ready && n < 200) begin
      step();
      n++;
    end
    step();
    div_valid = 1'b0;
    dividend = ~a;
    divisor = b ^ 64'h5;
    div_signed = ~sg;
  endtask

  task automatic run_op(string tag, bit sg, logic [W-1:0] a,
                        logic [W-1:0] b, exp_t e, int hold);
    int   cyc;
    exp_t got;
    sb.push_back(e);
    div_o_ready = 1'b0;
    issue(sg, a, b);
    cyc = 1;
    while (!div_o_valid && cyc < 200) begin
      step();
      cyc++;
    end
    got = sb.pop_front();
    chk({tag, "_lat"}, W'(cyc), W'(got.lat));
    chk({tag, "_q"}, quotient, got.q);
    chk({tag, "_r"}, remainder, got.r);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_v"}, W'(div_o_valid), W'(1));
      chk({tag, "_hold_q"}, quotient, got.q);
      chk({tag, "_hold_r"}, remainder, got.r);
    end
    div_o_ready = 1'b1;
    step();
    div_o_ready = 1'b0;
    chk({tag, "_exit_v"}, W'(div_o_valid), W'(0));
    chk({tag, "_exit_rdy"}, W'(div_i_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mn;
    bit           sg;
    int           seen;

    mn = '0;
    mn[W-1] = 1'b1;
    rst = 1'b1;
    div_flush = 1'b0;
    div_valid = 1'b0;
    div_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    div_o_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_q", quotient, '0);
    chk("rst_r", remainder, '0);
    chk("rst_v", W'(div_o_valid), W'(0));
    chk("rst_rdy", W'(div_i_ready), W'(1));

    run_op("u100_7", 1'b0, 64'd100, 64'd7,
           mk(64'd14, 64'd2, 65), 0);
    run_op("s_m7_2", 1'b1, -64'sd7, 64'd2,
           mk(64'hFFFF_FFFF_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFFF, 65), 0);
    run_op("dz_u", 1'b0, 64'h1234, 64'd0,
           mk('1, 64'h1234, 1), 0);
    run_op("dz_s", 1'b1, 64'h1234, 64'd0,
           mk('1, 64'h1234, 1), 0);
    run_op("ovf", 1'b1, mn, '1, mk(mn, '0, 1), 0);
    run_op("bp", 1'b0, 64'd1000, 64'd33,
           mk(64'd30, 64'd10, 65), 10);
    run_op("s_7_m2", 1'b1, 64'd7, -64'sd2,
           mk(-64'sd3, 64'd1, 65), 0);
    run_op("u_max_1", 1'b0, '1, 64'd1,
           mk('1, '0, 65), 0);

    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = (i % 2 == 0) ? W'($urandom_range(1, 1000))
                       : {$urandom, $urandom};
      sg = i[0] ^ i[1];
      run_op("rand", sg, a, b, model(sg, a, b),
             int'($urandom_range(0, 3)));
    end

    // request together with flush must not be taken
    div_signed = 1'b0;
    dividend = 64'd50;
    divisor = 64'd5;
    div_valid = 1'b1;
    div_flush = 1'b1;
    step();
    div_valid = 1'b0;
    div_flush = 1'b0;
    chk("flush_noacc_rdy", W'(div_i_ready), W'(1));

    // flush at cycle 30 of a divide
    issue(1'b0, 64'd999, 64'd3);
    for (int i = 0; i < 29; i++) step();
    div_flush = 1'b1;
    step();
    div_flush = 1'b0;
    chk("flush_rdy31", W'(div_i_ready), W'(1));
    chk("flush_v31", W'(div_o_valid), W'(0));
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (div_o_valid) seen++;
    end
    chk("flush_never_v", W'(seen), W'(0));

    // flush wins while a result is held in DONE
    issue(1'b0, 64'hABCD, 64'd0);
    chk("done_v", W'(div_o_valid), W'(1));
    div_flush = 1'b1;
    step();
    div_flush = 1'b0;
    chk("flush_done_v", W'(div_o_valid), W'(0));
    chk("flush_done_rdy", W'(div_i_ready), W'(1));

    // reset at cycle 30 of a divide
    issue(1'b1, -64'sd12345, 64'd17);
    for (int i = 0; i < 29; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_q", quotient, '0);
    chk("mrst_r", remainder, '0);
    chk("mrst_v", W'(div_o_valid), W'(0));
    chk("mrst_rdy", W'(div_i_ready), W'(1));
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (div_o_valid) seen++;
    end
    chk("mrst_never_v", W'(seen), W'(0));

    run_op("post_rst", 1'b0, 64'd81, 64'd9,
           mk(64'd9, 64'd0, 65), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 div_flush  input  1  abandons any in-flight or held operation.
REQ-005 div_valid  input  1  request valid; the requester holds it and all operands stable until accepted.
REQ-006 div_i_ready  output  1  request can be accepted; high only in IDLE.
REQ-007 div_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-008 dividend  input  WIDTH  dividend; word-mode extension is done by the requester.
REQ-009 divisor  input  WIDTH  divisor.
REQ-010 quotient  output  WIDTH  registered quotient.
REQ-011 remainder  output  WIDTH  registered remainder.
REQ-012 div_o_valid  output  1  result valid.
REQ-013 div_o_ready  input  1  consumer takes the result.

Function
REQ-014 FSM states are IDLE, CALC and DONE.
REQ-015 A request is accepted when div_valid, div_i_ready and !div_flush are all high at a rising edge.
- Operands are latched on acceptance.
- Signed mode latches the absolute values plus the sign of the quotient (sd^sv) and the sign of the remainder (sd).
REQ-016 IDLE->CALC on acceptance with a normal divide.
- IDLE->DONE on acceptance when divisor==0, or when signed with dividend=min-negative and divisor=-1.
REQ-017 CALC performs one restoring radix-2 step per cycle for exactly WIDTH cycles, tracked by a counter.
- Step: shift partial remainder left by 1 and bring in the next dividend bit (MSB first).
- Trial subtract the divisor; keep the difference if there is no borrow.
- The quotient bit is the inverted borrow.
REQ-018 On the final CALC cycle, apply sign correction (negate each result whose stored sign is 1), load quotient/remainder, and go to DONE.
REQ-019 Latency: acceptance edge at cycle 0.
- Normal divide: div_o_valid high from cycle WIDTH+1.
- Special cases: div_o_valid high from cycle 1.
REQ-020 Divide by zero: quotient = all ones, remainder = dividend, in both signed and unsigned modes.
REQ-021 Signed overflow (min-negative / -1): quotient = dividend, remainder = 0.
REQ-022 div_o_valid is high exactly in DONE.
- DONE->IDLE when div_o_ready is high.
- quotient/remainder stay stable while div_o_valid && !div_o_ready.
REQ-023 div_flush in any state forces IDLE at the next edge.
- div_o_valid is low from that edge on.
- A request presented together with flush is not accepted.
REQ-024 Flush has priority over div_o_ready in DONE; both lead to IDLE.
REQ-025 Only one operation is in flight at a time.
- No new acceptance in the cycle DONE exits.
- div_i_ready rises the cycle after the DONE->IDLE transition.
REQ-026 Inputs are ignored outside IDLE.

Reset
REQ-027 rst high at an edge forces the following, overriding all other inputs including mid-CALC operation:
- FSM = IDLE, counter = 0
- quotient = 0, remainder = 0
- div_o_valid = 0, div_i_ready = 1 after release.
REQ-028 After reset, no result from an earlier operation ever appears.

Structure
REQ-029 FSM state encodings (IDLE=0, CALC=1, DONE=2) are constants in the shared define file; WIDTH-derived counter width is computed locally.
REQ-030 The single iteration is a sub-module div_step: partial remainder, divisor and next dividend bit in; new remainder and quotient bit out, purely combinational.
REQ-031 Sign extraction/negation is inline; no other sub-modules.

Verification
REQ-032 Unsigned divide: unsigned, 100/7 -> quotient=14, remainder=2, div_o_valid rises exactly at cycle 65.
REQ-033 Signed divide: signed, -7/2 -> quotient=0xFFFF_FFFF_FFFF_FFFD, remainder=0xFFFF_FFFF_FFFF_FFFF.
REQ-034 Divide by zero: 0x1234/0, both modes -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234, div_o_valid at cycle 1.
REQ-035 Signed overflow: signed 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> quotient=0x8000_0000_0000_0000, remainder=0, at cycle 1.
REQ-036 Flush and reset mid-operation:
- div_flush at cycle 30 of a divide -> div_o_valid never asserts, div_i_ready high at cycle 31.
- Same test with rst instead of div_flush -> outputs back to 0.
REQ-037 Backpressure: div_o_ready low 10 cycles after div_o_valid -> quotient/remainder unchanged; the cycle after div_o_ready is asserted -> IDLE, div_o_valid low.
